// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for a 32-bit word memory with sub-word extraction,
// sign extension and read-modify-write for byte/halfword stores.
module mem_lsu #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] l_addr;
   logic [1:0] l_size, l_off;
   logic l_signed;
   logic [31:0] l_wdata;
   logic acc, err;
   logic [4:0] sh;
   logic [31:0] rsh, ext, mask, merged;
   assign req_ready = rst_n && state == IDLE;
   assign acc = req_valid && req_ready;
   assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign sh = {l_off, 3'b000};
   assign rsh = mem_rdata >> sh;
   assign ext = l_size == 2'b00 ? {{24{l_signed & rsh[7]}}, rsh[7:0]} :
                l_size == 2'b01 ? {{16{l_signed & rsh[15]}}, rsh[15:0]} : mem_rdata;
   assign mask = (l_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
   assign merged = (mem_rdata & ~mask) | ((l_wdata << sh) & mask);
   always_comb begin
      state_nx = state;
      mem_en = 1'b0;
      mem_we = 1'b0;
      mem_addr = l_addr;
      mem_wdata = merged;
      case (state)
         IDLE: begin
            mem_addr = req_addr[ADDR_W+1:2];
            mem_wdata = req_wdata;
            if (acc && !err) begin
               if (!req_we) begin
                  mem_en = 1'b1;
                  state_nx = LOAD_WAIT;
               end else if (req_size == 2'b10) begin
                  mem_we = 1'b1;
               end else begin
                  mem_en = 1'b1;
                  state_nx = RMW;
               end
            end
         end
         LOAD_WAIT: state_nx = IDLE;
         RMW: begin
            mem_we = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         l_addr <= '0;
         l_size <= '0;
         l_off <= '0;
         l_signed <= 1'b0;
         l_wdata <= '0;
         resp_valid <= 1'b0;
         resp_err <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            l_addr <= req_addr[ADDR_W+1:2];
            l_size <= req_size;
            l_off <= req_addr[1:0];
            l_signed <= req_signed;
            l_wdata <= req_wdata;
         end
         // word stores and errors answer from IDLE; multi-cycle accesses answer on leaving their state
         resp_valid <= (acc && (err || (req_we && req_size == 2'b10))) || state != IDLE;
         resp_err <= acc && err;
         resp_rdata <= state == LOAD_WAIT ? ext : '0;
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scoreboard bench for mem_lsu with a behavioural word memory
// and a shadow memory that predicts load data and store effects.
module tb_mem_lsu;
   localparam int AW = 14;
   localparam int DEPTH = 1 << AW;
   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   logic req_valid, req_ready, req_we, req_signed;
   logic [1:0] req_size;
   logic [AW+1:0] req_addr;
   logic [31:0] req_wdata;
   logic resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] shw [0:DEPTH-1];
   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int quiet_hits = 0;
   logic quiet = 1'b0;
   mem_lsu #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem_en ? mem[mem_addr] : 'x;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic is_err(input logic [1:0] size, input logic [1:0] a);
      return size == 2'd3 || (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'd0);
   endfunction
   function automatic logic [31:0] ld_exp(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] size, input logic sg);
      logic [7:0] b;
      logic [15:0] h;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      if (size == 2'd0) return sg ? {{24{b[7]}}, b} : {24'd0, b};
      if (size == 2'd1) return sg ? {{16{h[15]}}, h} : {16'd0, h};
      return w;
   endfunction
   function automatic logic [31:0] st_apply(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (size == 2'd0) r[8*a +: 8] = d[7:0];
      else if (size == 2'd1 && a[1]) r[31:16] = d[15:0];
      else if (size == 2'd1) r[15:0] = d[15:0];
      else r = d;
      return r;
   endfunction
   // drives one request and returns #1 after its accept edge with req_valid dropped
   task automatic issue(input logic we, input logic [1:0] size, input logic sg,
                        input logic [AW+1:0] addr, input logic [31:0] wdata, input bit push);
      int n = 0;
      int wi = int'(addr[AW+1:2]);
      req_valid = 1'b1;
      req_we = we;
      req_size = size;
      req_signed = sg;
      req_addr = addr;
      req_wdata = wdata;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 20), 1);
      if (push) begin
         if (is_err(size, addr[1:0])) q.push_back('{d: 32'd0, e: 1'b1});
         else if (!we) q.push_back('{d: ld_exp(shw[wi], addr[1:0], size, sg), e: 1'b0});
         else begin
            shw[wi] = st_apply(shw[wi], addr[1:0], size, wdata);
            q.push_back('{d: 32'd0, e: 1'b0});
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 0);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (quiet && (mem_en || mem_we)) quiet_hits++;
      if (rst_n && resp_valid) begin
         check("resp_has_request", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("resp_rdata", resp_rdata, e.d);
            check("resp_err", 32'(resp_err), 32'(e.e));
         end
      end
   end
   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'd0;
      req_signed = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'd0;
         shw[i] = 32'd0;
      end
      repeat (2) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", 32'(resp_err), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 1);
      // word store then word load of the same location
      issue(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF, 1'b1);
      check("st_word_mem", mem[4], 32'hDEAD_BEEF);
      check("st_word_resp", 32'(resp_valid), 1);
      issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 1'b1);
      check("ld_busy_ready", 32'(req_ready), 0);
      check("ld_resp_early", 32'(resp_valid), 0);
      @(posedge clk);
      #1;
      check("ld_resp_valid", 32'(resp_valid), 1);
      check("ld_resp_data", resp_rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      // byte store through read-modify-write
      mem[4] = 32'h1122_3344;
      shw[4] = 32'h1122_3344;
      issue(1'b1, 2'd0, 1'b0, 16'h0012, 32'h0000_00AA, 1'b1);
      check("rmw_we", 32'(mem_we), 1);
      check("rmw_addr", 32'(mem_addr), 4);
      check("rmw_wdata", mem_wdata, 32'h11AA_3344);
      check("rmw_resp_early", 32'(resp_valid), 0);
      @(posedge clk);
      #1;
      check("rmw_mem", mem[4], 32'h11AA_3344);
      check("rmw_resp_valid", 32'(resp_valid), 1);
      check("rmw_we_done", 32'(mem_we), 0);
      @(posedge clk);
      #1;
      // sub-word loads with sign/zero extension, back to back
      mem[4] = 32'h8000_F0FF;
      shw[4] = 32'h8000_F0FF;
      issue(1'b0, 2'd0, 1'b1, 16'h0010, 32'd0, 1'b1);
      issue(1'b0, 2'd1, 1'b0, 16'h0012, 32'd0, 1'b1);
      issue(1'b0, 2'd1, 1'b1, 16'h0012, 32'd0, 1'b1);
      issue(1'b0, 2'd0, 1'b0, 16'h0011, 32'd0, 1'b1);
      issue(1'b0, 2'd0, 1'b1, 16'h0013, 32'd0, 1'b1);
      issue(1'b0, 2'd1, 1'b1, 16'h0010, 32'd0, 1'b1);
      // halfword and byte stores into a fresh word, then read it back
      issue(1'b1, 2'd1, 1'b0, 16'h0020, 32'hABCD_1234, 1'b1);
      issue(1'b1, 2'd0, 1'b0, 16'h0023, 32'h0000_0155, 1'b1);
      issue(1'b1, 2'd1, 1'b0, 16'hFFFE, 32'h0000_BEEF, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 16'h0020, 32'd0, 1'b1);
      issue(1'b0, 2'd1, 1'b1, 16'hFFFE, 32'd0, 1'b1);
      drain();
      check("sub_store_mem", mem[8], 32'h5500_1234);
      check("top_word_mem", mem[DEPTH-1], 32'hBEEF_0000);
      // misaligned and illegal accesses, one per cycle, no memory traffic
      @(posedge clk);
      #1 quiet = 1'b1;
      issue(1'b0, 2'd1, 1'b0, 16'h0011, 32'd0, 1'b1);
      issue(1'b1, 2'd2, 1'b0, 16'h0012, 32'h1234_5678, 1'b1);
      check("err_throughput", 32'(resp_valid), 1);
      issue(1'b0, 2'd3, 1'b0, 16'h0010, 32'd0, 1'b1);
      drain();
      @(posedge clk);
      #1 quiet = 1'b0;
      check("err_no_mem", 32'(quiet_hits), 0);
      check("err_mem_kept", mem[4], 32'h8000_F0FF);
      // reset while a byte store sits in RMW aborts it
      issue(1'b1, 2'd0, 1'b0, 16'h0010, 32'h0000_00AA, 1'b0);
      check("abort_in_rmw", 32'(mem_we), 1);
      rst_n = 1'b0;
      quiet = 1'b1;
      #1;
      check("abort_we", 32'(mem_we), 0);
      check("abort_ready", 32'(req_ready), 0);
      check("abort_resp", 32'(resp_valid), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ready_after", 32'(req_ready), 1);
      repeat (3) @(posedge clk);
      #1 quiet = 1'b0;
      check("abort_no_mem", 32'(quiet_hits), 0);
      check("abort_mem_kept", mem[4], shw[4]);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
